// File: rtl/lcd_init_seq_if.sv
// -----------------------------------------------------------------------------
// lcd_init_seq_if
//   Write-request channel between the LCD init sequencer and the 8080 bus
//   writer. A transfer completes on any clock where wr_valid & wr_ready.
//   Signals:
//     wr_valid  sequencer -> writer  write request
//     wr_dc     sequencer -> writer  0 = command, 1 = data/pixel
//     wr_data   sequencer -> writer  16-bit payload
//     wr_ready  writer -> sequencer  writer can accept this cycle
// -----------------------------------------------------------------------------
interface lcd_init_seq_if;
  logic        wr_valid;
  logic        wr_dc;
  logic [15:0] wr_data;
  logic        wr_ready;

  modport master (output wr_valid, output wr_dc, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_dc, input wr_data, output wr_ready);
endinterface

// File: rtl/lcd_init_seq.sv
// -----------------------------------------------------------------------------
// lcd_init_seq
//   Brings up the LCD panel. It walks an init ROM of CMD / DATA / DELAY / END
//   entries and issues every CMD/DATA entry as a write on the valid/ready
//   channel. After END it optionally streams one full frame of a fixed colour,
//   then raises a sticky init_done.
//   Ports:
//     clk, rstn    clock, asynchronous active-low reset
//     start        1-cycle pulse, accepted only in IDLE/DONE
//     fill_en      sampled at start: perform frame fill after END
//     fill_color   sampled at start: RGB565 fill value
//     rom_addr     registered ROM address
//     rom_data     synchronous ROM data, valid one clock after rom_addr
//                  [17:16] 00=CMD 01=DATA 10=DELAY 11=END, [15:0] payload
//     wr           write channel to the bus writer (master side)
//     busy         high in every state except IDLE/DONE
//     init_done    sticky completion flag, cleared by the next start
// -----------------------------------------------------------------------------
module lcd_init_seq #(
  parameter int ROM_AW       = 7,
  parameter int ROM_DEPTH    = 107,
  parameter int FRAME_PIXELS = 76800,
  parameter int PIX_W        = 17,
  parameter int DLY_TICKS    = 50000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              fill_en,
  input  logic [15:0]       fill_color,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [17:0]       rom_data,
  lcd_init_seq_if.master    wr,
  output logic              busy,
  output logic              init_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WRITE, S_DELAY, S_FILL, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    T_CMD = 2'b00, T_DATA = 2'b01, T_DELAY = 2'b10, T_END = 2'b11
  } entry_e;

  localparam int                TICK_W    = (DLY_TICKS > 1) ? $clog2(DLY_TICKS) : 1;
  localparam logic [ROM_AW-1:0] END_ADDR  = ROM_AW'(ROM_DEPTH);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DLY_TICKS - 1);
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(FRAME_PIXELS - 1);

  state_e              state_q, state_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic                wr_valid_q, wr_valid_d;
  logic                wr_dc_q, wr_dc_d;
  logic [15:0]         wr_data_q, wr_data_d;
  logic                init_done_q, init_done_d;
  logic                fill_en_q, fill_en_d;
  logic [15:0]         fill_color_q, fill_color_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [15:0]         unit_q, unit_d;
  logic [PIX_W-1:0]    pix_q, pix_d;

  entry_e      entry_type;
  logic [15:0] payload;
  logic        take_end;   // END reached, either by an END entry or by address
  logic        addr_inc;

  assign entry_type = entry_e'(rom_data[17:16]);
  assign payload    = rom_data[15:0];

  // NOTE: every variable written here gets its default first, so no path
  // through the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    wr_valid_d   = wr_valid_q;
    wr_dc_d      = wr_dc_q;
    wr_data_d    = wr_data_q;
    init_done_d  = init_done_q;
    fill_en_d    = fill_en_q;
    fill_color_d = fill_color_q;
    tick_d       = tick_q;
    unit_d       = unit_q;
    pix_d        = pix_q;
    take_end     = 1'b0;
    addr_inc     = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          fill_en_d    = fill_en;
          fill_color_d = fill_color;
          rom_addr_d   = '0;
          init_done_d  = 1'b0;
          state_d      = S_FETCH;
        end
      end

      S_FETCH: begin
        // A ROM without an END entry terminates at ROM_DEPTH; the data at
        // that address is never used.
        if (rom_addr_q == END_ADDR) take_end = 1'b1;
        else                        state_d  = S_DECODE;
      end

      S_DECODE: begin
        unique case (entry_type)
          T_CMD, T_DATA: begin
            wr_dc_d    = (entry_type == T_DATA);
            wr_data_d  = payload;
            wr_valid_d = 1'b1;
            state_d    = S_WRITE;
          end
          T_DELAY: begin
            if (payload == 16'd0) begin
              addr_inc = 1'b1;
              state_d  = S_FETCH;
            end else begin
              unit_d  = payload;
              tick_d  = '0;
              state_d = S_DELAY;
            end
          end
          T_END: take_end = 1'b1;
          default: ;
        endcase
      end

      S_WRITE: begin
        if (wr.wr_ready) begin
          wr_valid_d = 1'b0;
          addr_inc   = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_DELAY: begin
        // tick_q counts clocks inside one unit, unit_q counts units left.
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (unit_q == 16'd1) begin
            addr_inc = 1'b1;
            state_d  = S_FETCH;
          end else begin
            unit_d = unit_q - 16'd1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end

      S_FILL: begin
        if (wr.wr_ready) begin
          if (pix_q == PIX_LAST) begin
            wr_valid_d  = 1'b0;
            init_done_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            pix_d = pix_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (take_end) begin
      if (fill_en_q) begin
        wr_valid_d = 1'b1;
        wr_dc_d    = 1'b1;
        wr_data_d  = fill_color_q;
        pix_d      = '0;
        state_d    = S_FILL;
      end else begin
        init_done_d = 1'b1;
        state_d     = S_DONE;
      end
    end

    // Saturate at END_ADDR so the address can never wrap back to 0.
    if (addr_inc && (rom_addr_q != END_ADDR)) rom_addr_d = rom_addr_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      rom_addr_q   <= '0;
      wr_valid_q   <= 1'b0;
      wr_dc_q      <= 1'b0;
      wr_data_q    <= '0;
      init_done_q  <= 1'b0;
      fill_en_q    <= 1'b0;
      fill_color_q <= '0;
      tick_q       <= '0;
      unit_q       <= '0;
      pix_q        <= '0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      wr_valid_q   <= wr_valid_d;
      wr_dc_q      <= wr_dc_d;
      wr_data_q    <= wr_data_d;
      init_done_q  <= init_done_d;
      fill_en_q    <= fill_en_d;
      fill_color_q <= fill_color_d;
      tick_q       <= tick_d;
      unit_q       <= unit_d;
      pix_q        <= pix_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign wr.wr_valid = wr_valid_q;
  assign wr.wr_dc    = wr_dc_q;
  assign wr.wr_data  = wr_data_q;
  assign init_done   = init_done_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_lcd_init_seq.sv
// -----------------------------------------------------------------------------
// tb_lcd_init_seq
//   Self-checking bench for lcd_init_seq with DLY_TICKS=4, FRAME_PIXELS=8,
//   ROM_DEPTH=6. A table of ROM images drives most runs; a reference walk of
//   each image fills a scoreboard queue that the write monitor pops. Timing
//   gaps between transfers, done latency, address bound and reset-in-fill
//   are checked on top.
// -----------------------------------------------------------------------------
module tb_lcd_init_seq;

  localparam int ROM_AW    = 7;
  localparam int ROM_DEPTH = 6;
  localparam int FRAME     = 8;
  localparam int PIX_W     = 4;
  localparam int DLY       = 4;

  localparam logic [1:0] CMD = 2'b00, DAT = 2'b01, DLYT = 2'b10, ENDT = 2'b11;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              fill_en = 1'b0;
  logic [15:0]       fill_color = '0;
  logic [ROM_AW-1:0] rom_addr;
  logic [17:0]       rom_data = '0;
  logic              busy;
  logic              init_done;

  lcd_init_seq_if wr_if ();

  lcd_init_seq #(
    .ROM_AW(ROM_AW), .ROM_DEPTH(ROM_DEPTH), .FRAME_PIXELS(FRAME),
    .PIX_W(PIX_W), .DLY_TICKS(DLY)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .fill_en(fill_en),
    .fill_color(fill_color), .rom_addr(rom_addr), .rom_data(rom_data),
    .wr(wr_if.master), .busy(busy), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model
  logic [17:0] rom_mem [128];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // Ready driver: fixed high or random, changed just after each rising edge
  bit rand_rdy = 1'b0;
  initial wr_if.wr_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    wr_if.wr_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard and monitor (samples on the falling edge)
  logic [16:0] exp_q[$];
  int          hs_cyc[$];
  int          cyc = 0;
  int          n_hs = 0;
  int          start_cyc = -1;
  int          done_cyc = -1;
  int          max_addr = 0;
  bit          done_prev = 1'b0;
  bit          stall_prev = 1'b0;
  logic        prev_dc;
  logic [15:0] prev_data;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      stall_prev = 1'b0;
      done_prev  = 1'b0;
    end else begin
      if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
      if (start && !busy) start_cyc = cyc;
      if (init_done && !done_prev) done_cyc = cyc;
      done_prev = init_done;
      if (stall_prev) begin
        check("hold_valid", 32'(wr_if.wr_valid), 32'd1);
        check("hold_dc",    32'(wr_if.wr_dc),    32'(prev_dc));
        check("hold_data",  32'(wr_if.wr_data),  32'(prev_data));
      end
      stall_prev = wr_if.wr_valid && !wr_if.wr_ready;
      prev_dc    = wr_if.wr_dc;
      prev_data  = wr_if.wr_data;
      if (wr_if.wr_valid && wr_if.wr_ready) begin
        hs_cyc.push_back(cyc);
        n_hs++;
        if (exp_q.size() == 0) begin
          check("extra_xfer", 32'({wr_if.wr_dc, wr_if.wr_data}), 32'h1FFFF);
        end else begin
          check("xfer", 32'({wr_if.wr_dc, wr_if.wr_data}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  typedef struct {
    string            name;
    logic [5:0][17:0] rom;
    logic             fill;
    logic [15:0]      color;
    bit               rnd;
    bit               mid_start;
    int               gap1;      // expected samples between 1st and 2nd transfer, -1 = skip
    int               done_gap;  // samples from last transfer to init_done rise
  } vec_t;

  function automatic logic [17:0] ent(input logic [1:0] t, input logic [15:0] p);
    return {t, p};
  endfunction

  function automatic logic [5:0][17:0] rom6(input logic [17:0] e0, e1, e2, e3, e4, e5);
    logic [5:0][17:0] r;
    r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3; r[4] = e4; r[5] = e5;
    return r;
  endfunction

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic load_and_model(input vec_t v);
    logic [1:0] t;
    for (int i = 0; i < 128; i++) rom_mem[i] = (i < 6) ? v.rom[i] : ent(CMD, 16'h0BAD);
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      t = v.rom[i][17:16];
      if (t == ENDT) break;
      if (t == CMD) exp_q.push_back({1'b0, v.rom[i][15:0]});
      if (t == DAT) exp_q.push_back({1'b1, v.rom[i][15:0]});
    end
    if (v.fill) for (int i = 0; i < FRAME; i++) exp_q.push_back({1'b1, v.color});
    hs_cyc.delete();
    n_hs = 0; max_addr = 0; done_cyc = -1; start_cyc = -1;
  endtask

  task automatic run_vec(input vec_t v);
    bit got_done;
    load_and_model(v);
    rand_rdy   = v.rnd;
    fill_en    = v.fill;
    fill_color = v.color;
    pulse_start();
    check({v.name, "_busy_after_start"}, 32'(busy), 32'd1);
    check({v.name, "_done_cleared"}, 32'(init_done), 32'd0);
    // Latched values must not follow later input changes.
    fill_color = ~v.color;
    fill_en    = ~v.fill;
    if (v.mid_start) begin
      repeat (4) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    got_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (init_done) begin got_done = 1'b1; break; end
    end
    check({v.name, "_done_in_time"}, 32'(got_done), 32'd1);
    repeat (2) @(negedge clk);
    #1;
    check({v.name, "_xfers_left"}, 32'(exp_q.size()), 32'd0);
    check({v.name, "_init_done"}, 32'(init_done), 32'd1);
    check({v.name, "_busy_idle"}, 32'(busy), 32'd0);
    check({v.name, "_valid_low"}, 32'(wr_if.wr_valid), 32'd0);
    check({v.name, "_addr_bound"}, 32'(max_addr <= ROM_DEPTH), 32'd1);
    check({v.name, "_done_gap"}, 32'(done_cyc - hs_cyc[hs_cyc.size()-1]), 32'(v.done_gap));
    if (!v.rnd) check({v.name, "_first_latency"}, 32'(hs_cyc[0] - start_cyc), 32'd3);
    if (v.gap1 >= 0) check({v.name, "_gap1"}, 32'(hs_cyc[1] - hs_cyc[0]), 32'(v.gap1));
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"basic", rom6(ent(CMD, 16'h0011), ent(DAT, 16'h0055), ent(ENDT, 0),
                ent(ENDT, 0), ent(ENDT, 0), ent(ENDT, 0)),
                1'b0, 16'h0000, 1'b0, 1'b0, 3, 3};
    vecs[1] = '{"delay3", rom6(ent(CMD, 16'h0001), ent(DLYT, 16'd3), ent(CMD, 16'h0029),
                ent(ENDT, 0), ent(ENDT, 0), ent(ENDT, 0)),
                1'b0, 16'h0000, 1'b0, 1'b0, 17, 3};
    vecs[2] = '{"delay0", rom6(ent(CMD, 16'h0001), ent(DLYT, 16'd0), ent(CMD, 16'h0029),
                ent(ENDT, 0), ent(ENDT, 0), ent(ENDT, 0)),
                1'b0, 16'h0000, 1'b0, 1'b0, 5, 3};
    vecs[3] = '{"fill_rand", rom6(ent(CMD, 16'h002C), ent(ENDT, 0), ent(ENDT, 0),
                ent(ENDT, 0), ent(ENDT, 0), ent(ENDT, 0)),
                1'b1, 16'hF800, 1'b1, 1'b0, -1, 1};
    vecs[4] = '{"no_end", rom6(ent(CMD, 16'h00A0), ent(DAT, 16'h00A1), ent(CMD, 16'h00A2),
                ent(DAT, 16'h00A3), ent(CMD, 16'h00A4), ent(DAT, 16'h00A5)),
                1'b0, 16'h0000, 1'b0, 1'b0, 3, 2};
    vecs[5] = '{"mixed_fill", rom6(ent(CMD, 16'h0036), ent(DAT, 16'h0048), ent(DLYT, 16'd1),
                ent(CMD, 16'h002C), ent(ENDT, 0), ent(ENDT, 0)),
                1'b1, 16'h07E0, 1'b0, 1'b1, 3, 1};

    for (int i = 0; i < 128; i++) rom_mem[i] = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_valid", 32'(wr_if.wr_valid), 32'd0);
    check("rst_dc", 32'(wr_if.wr_dc), 32'd0);
    check("rst_data", 32'(wr_if.wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(init_done), 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      if (vecs[i].name == "no_end") check("no_end_addr", 32'(rom_addr), 32'(ROM_DEPTH));
    end

    // Reset asserted in the middle of the frame fill
    begin
      vec_t v;
      bit in_fill;
      v = vecs[3];
      v.rnd = 1'b0;
      v.color = 16'h001F;
      load_and_model(v);
      rand_rdy = 1'b0;
      fill_en = 1'b1;
      fill_color = v.color;
      pulse_start();
      in_fill = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (n_hs >= 3) begin in_fill = 1'b1; break; end
      end
      check("rstfill_reached", 32'(in_fill), 32'd1);
      #2 rstn = 1'b0;
      #1;
      check("rstfill_valid", 32'(wr_if.wr_valid), 32'd0);
      check("rstfill_done", 32'(init_done), 32'd0);
      check("rstfill_busy", 32'(busy), 32'd0);
      check("rstfill_addr", 32'(rom_addr), 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      check("rstfill_idle_valid", 32'(wr_if.wr_valid), 32'd0);
      check("rstfill_idle_busy", 32'(busy), 32'd0);
    end

    // A new start replays the ROM from address 0
    run_vec(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
